// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed seven-segment scanner fed by the bus seg7 register
// Ports: clk, rst (sync, active-high); seg7_we/cpuseg7_data bus write; sw_i switches;
//        dbg_data debug word; disp_sel source (0 cpu, 1 switches, 2 debug, 3 zero);
//        disp_an active-low anodes; disp_seg active-low {dp,g..a}; cpu_reg_q register readback.
// Optional: define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned PRESC_W  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg7_we,
    input  logic [31:0] cpuseg7_data,
    input  logic [15:0] sw_i,
    input  logic [31:0] dbg_data,
    input  logic [1:0]  disp_sel,
    output logic [7:0]  disp_an,
    output logic [7:0]  disp_seg,
    output logic [31:0] cpu_reg_q
);
    logic [31:0]        cpu_reg_d, shadow_q, shadow_d, src;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         an_q, an_d, seg_q, seg_d;
    logic [3:0]         nib;
    logic               term, blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        term      = presc_q == PRESC_W'(SCAN_DIV - 1);
        presc_d   = term ? '0 : presc_q + PRESC_W'(1);
        idx_d     = term ? idx_q + 3'd1 : idx_q;
        src       = disp_sel == 2'd0 ? cpu_reg_q :
                    disp_sel == 2'd1 ? {16'h0, sw_i} :
                    disp_sel == 2'd2 ? dbg_data : 32'h0;
        // the pre-write register is captured, so a same-edge write waits a frame
        shadow_d  = (term && idx_q == 3'd7) ? src : shadow_q;
        cpu_reg_d = seg7_we ? cpuseg7_data : cpu_reg_q;
        nib       = 4'(shadow_q >> {idx_q, 2'b00});
`ifdef SEG7_LZ_BLANK_EN
        // everything from this nibble upward is zero; digit 0 is never blanked
        blank     = (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == 32'h0);
`else
        blank     = 1'b0;
`endif
        an_d      = ~(8'b1 << idx_q);
        seg_d     = blank ? 8'hFF : {1'b1, hex7(nib)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_reg_q <= '0;
            shadow_q  <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            an_q      <= 8'hFF;
            seg_q     <= 8'hFF;
        end else begin
            cpu_reg_q <= cpu_reg_d;
            shadow_q  <= shadow_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign disp_an  = an_q;
    assign disp_seg = seg_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed bench for seg7_scan_ctrl with SCAN_DIV=4
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seg7_we = 1'b0;
    logic [31:0] cpuseg7_data = '0;
    logic [15:0] sw_i = '0;
    logic [31:0] dbg_data = '0;
    logic [1:0]  disp_sel = '0;
    logic [7:0]  disp_an, disp_seg;
    logic [31:0] cpu_reg_q;
    int total = 0;
    int bad = 0;
    int k = 0;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [7:0] ZHI = 8'hFF;
`else
    localparam logic [7:0] ZHI = 8'hC0;
`endif

    seg7_scan_ctrl #(.SCAN_DIV(4), .PRESC_W(17)) dut (
        .clk(clk), .rst(rst), .seg7_we(seg7_we), .cpuseg7_data(cpuseg7_data),
        .sw_i(sw_i), .dbg_data(dbg_data), .disp_sel(disp_sel),
        .disp_an(disp_an), .disp_seg(disp_seg), .cpu_reg_q(cpu_reg_q)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic at(input int t);
        step(t - k);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic dig(input string tag, input logic [7:0] an, input logic [7:0] seg);
        chk({tag, "_an"}, 32'(disp_an), 32'(an));
        chk({tag, "_seg"}, 32'(disp_seg), 32'(seg));
    endtask

    initial begin
        step(3);
        chk("rst_an", 32'(disp_an), 32'hFF);
        chk("rst_seg", 32'(disp_seg), 32'hFF);
        chk("rst_cpu", cpu_reg_q, 32'h0);
        rst = 1'b0;
        k = 0;
        at(1);  dig("scan0", 8'hFE, 8'hC0);
        at(4);  dig("scan0_hold", 8'hFE, 8'hC0);
        at(5);  dig("scan1", 8'hFD, ZHI);
        at(9);  chk("scan2", 32'(disp_an), 32'hFB);
        at(21); chk("scan5", 32'(disp_an), 32'hDF);
        at(29); dig("scan7", 8'h7F, ZHI);
        at(33); dig("scan_wrap", 8'hFE, 8'hC0);

        seg7_we = 1'b1; cpuseg7_data = 32'h1234ABCD;
        step(1);
        seg7_we = 1'b0; cpuseg7_data = '0;
        chk("cpu_wr", cpu_reg_q, 32'h1234ABCD);
        chk("no_tear_d0", 32'(disp_seg), 32'hC0);
        at(64); dig("no_tear_d7", 8'h7F, ZHI);
        at(65); dig("w_d0", 8'hFE, 8'hA1);
        at(69); dig("w_d1", 8'hFD, 8'hC6);
        at(73); chk("w_d2", 32'(disp_seg), 32'h83);
        at(77); chk("w_d3", 32'(disp_seg), 32'h88);
        at(81); chk("w_d4", 32'(disp_seg), 32'h99);
        at(85); chk("w_d5", 32'(disp_seg), 32'hB0);
        at(89); chk("w_d6", 32'(disp_seg), 32'hA4);
        at(93); dig("w_d7", 8'h7F, 8'hF9);

        at(95);
        seg7_we = 1'b1; cpuseg7_data = 32'hFFFFFFFF;
        step(1);
        seg7_we = 1'b0; cpuseg7_data = '0;
        chk("coll_cpu", cpu_reg_q, 32'hFFFFFFFF);
        at(97);  dig("coll_old_d0", 8'hFE, 8'hA1);
        at(125); chk("coll_old_d7", 32'(disp_seg), 32'hF9);
        at(129); dig("coll_new_d0", 8'hFE, 8'h8E);
        at(145); chk("coll_new_d4", 32'(disp_seg), 32'h8E);
        at(157); chk("coll_new_d7", 32'(disp_seg), 32'h8E);

        disp_sel = 2'd1; sw_i = 16'hBEEF;
        at(160); chk("sel_late", 32'(disp_seg), 32'h8E);
        at(161); chk("sw_d0", 32'(disp_seg), 32'h8E);
        at(165); chk("sw_d1", 32'(disp_seg), 32'h86);
        at(169); chk("sw_d2", 32'(disp_seg), 32'h86);
        at(173); chk("sw_d3", 32'(disp_seg), 32'h83);
        at(177); chk("sw_d4", 32'(disp_seg), 32'(ZHI));
        at(189); chk("sw_d7", 32'(disp_seg), 32'(ZHI));

        disp_sel = 2'd2; dbg_data = 32'h00400010;
        at(193); chk("dbg_d0", 32'(disp_seg), 32'hC0);
        at(197); chk("dbg_d1", 32'(disp_seg), 32'hF9);
        at(201); chk("dbg_d2", 32'(disp_seg), 32'hC0);
        at(213); chk("dbg_d5", 32'(disp_seg), 32'h99);
        at(217); chk("dbg_d6", 32'(disp_seg), 32'(ZHI));
        at(221); chk("dbg_d7", 32'(disp_seg), 32'(ZHI));

        disp_sel = 2'd3;
        at(225); dig("zero_d0", 8'hFE, 8'hC0);
        at(229); chk("zero_d1", 32'(disp_seg), 32'(ZHI));
        at(253); chk("zero_d7", 32'(disp_seg), 32'(ZHI));

        disp_sel = 2'd0;
        at(257); chk("ff_d0", 32'(disp_seg), 32'h8E);
        at(278); dig("pre_rst_d5", 8'hDF, 8'h8E);
        rst = 1'b1;
        step(1);
        chk("mid_rst_an", 32'(disp_an), 32'hFF);
        chk("mid_rst_seg", 32'(disp_seg), 32'hFF);
        chk("mid_rst_cpu", cpu_reg_q, 32'h0);
        rst = 1'b0;
        k = 0;
        at(1); dig("restart_d0", 8'hFE, 8'hC0);

        seg7_we = 1'b1; cpuseg7_data = 32'h11111111;
        step(1);
        cpuseg7_data = 32'h00000305;
        step(1);
        seg7_we = 1'b0; cpuseg7_data = '0;
        chk("b2b_cpu", cpu_reg_q, 32'h00000305);
        at(5);  dig("restart_d1", 8'hFD, ZHI);
        at(33); dig("lz_d0", 8'hFE, 8'h92);
        at(37); chk("lz_d1", 32'(disp_seg), 32'hC0);
        at(41); chk("lz_d2", 32'(disp_seg), 32'hB0);
        at(45); dig("lz_d3", 8'hF7, ZHI);
        at(61); dig("lz_d7", 8'h7F, ZHI);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
